// File: rtl/jet_sched_pkg.sv
// Shared constants and FSM encoding for the jet-finding mux scheduler.
package jet_sched_pkg;
  localparam logic [3:0] SEL_IDLE = 4'b1000;
  localparam int         N_IN     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit encoder for an 8-bit request vector.
module prio_enc8
  import jet_sched_pkg::*;
(
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);
  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (in[i]) idx = 3'(i);
    end
  end

  assign any = |in;
endmodule

// File: rtl/prio_mux8_sched.sv
// Frame scheduler: issues one registered prio_mux8 select per cycle, lowest
// pending request first, with valid/index/last flags aligned to the mux output.
module prio_mux8_sched
  import jet_sched_pkg::*;
#(
  parameter int MAX_GRANTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] req,
  output logic [3:0] sel,
  output logic       sel_vld,
  output logic       o_valid,
  output logic [2:0] o_idx,
  output logic       o_last,
  output logic       done,
  output logic [3:0] o_cnt,
  output logic       busy
);
  state_t     state, state_nxt;
  logic [7:0] pend;
  logic [3:0] cnt;
  logic       sel_last;

  logic [2:0] p;
  logic       any;
  logic [7:0] pend_clr;
  logic [3:0] cnt_inc;
  logic       final_grant;
  logic       accept;

  prio_enc8 u_enc (
    .in  (pend),
    .idx (p),
    .any (any)
  );

  assign pend_clr    = pend & ~(8'b1 << p);
  assign cnt_inc     = cnt + 4'd1;
  assign final_grant = !any || (pend_clr == 8'd0) || (cnt_inc == 4'(MAX_GRANTS));
  assign accept      = start && (state != SCAN);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (req != 8'd0) ? SCAN : DONE;
      SCAN:    if (final_grant) state_nxt = DONE;
      DONE:    if (start) state_nxt = (req != 8'd0) ? SCAN : DONE;
                else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      cnt      <= '0;
      sel      <= SEL_IDLE;
      sel_vld  <= 1'b0;
      sel_last <= 1'b0;
      o_valid  <= 1'b0;
      o_idx    <= '0;
      o_last   <= 1'b0;
      done     <= 1'b0;
      o_cnt    <= '0;
    end else begin
      o_valid <= sel_vld;
      o_idx   <= sel[2:0];
      o_last  <= sel_last;
      done    <= (state == DONE);
      if (state == SCAN) begin
        sel      <= {1'b0, p};
        sel_vld  <= any;
        sel_last <= final_grant;
        pend     <= pend_clr;
        cnt      <= cnt_inc;
      end else begin
        sel      <= SEL_IDLE;
        sel_vld  <= 1'b0;
        sel_last <= 1'b0;
        if (state == DONE) o_cnt <= cnt;
        if (accept) begin
          pend <= req;
          cnt  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_prio_mux8_sched.sv
// Bench for prio_mux8_sched: two instances (MAX_GRANTS 8 and 3) against a
// timeline model built from frame rules, plus literal spot checks.
module tb_prio_mux8_sched;
  localparam int SZ = 256;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] req;

  logic [3:0] sel     [2];
  logic       sel_vld [2];
  logic       o_valid [2];
  logic [2:0] o_idx   [2];
  logic       o_last  [2];
  logic       done    [2];
  logic [3:0] o_cnt   [2];
  logic       busy    [2];

  prio_mux8_sched #(.MAX_GRANTS(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .req(req),
    .sel(sel[0]), .sel_vld(sel_vld[0]), .o_valid(o_valid[0]), .o_idx(o_idx[0]),
    .o_last(o_last[0]), .done(done[0]), .o_cnt(o_cnt[0]), .busy(busy[0])
  );

  prio_mux8_sched #(.MAX_GRANTS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .req(req),
    .sel(sel[1]), .sel_vld(sel_vld[1]), .o_valid(o_valid[1]), .o_idx(o_idx[1]),
    .o_last(o_last[1]), .done(done[1]), .o_cnt(o_cnt[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Expected values after each edge, indexed by edge number.
  int e_sel [2][SZ];
  int e_sv  [2][SZ];
  int e_ov  [2][SZ];
  int e_idx [2][SZ];
  int e_last[2][SZ];
  int e_done[2][SZ];
  int e_cnt [2][SZ];
  int e_busy[2][SZ];
  int next_acc[2];
  int mg[2] = '{8, 3};
  int cyc = 0;
  bit armed = 1'b0;

  // Observed logs used by the literal checks.
  int s_log[2][SZ];
  int x_log[2][SZ];
  int l_log[2][SZ];
  int v_log[2][SZ];
  int d_log[2][SZ];
  int c_log[2][SZ];

  function automatic void wipe(input int d, input int from);
    for (int j = from; j < SZ; j++) begin
      e_sel[d][j] = 8; e_sv[d][j] = 0; e_ov[d][j] = 0; e_idx[d][j] = 0;
      e_last[d][j] = 0; e_done[d][j] = 0; e_cnt[d][j] = 0; e_busy[d][j] = 0;
    end
  endfunction

  function automatic void frame(input int d, input int m, input logic [7:0] r);
    int g[8];
    int k = 0;
    for (int i = 0; i < 8; i++)
      if (r[i] && k < mg[d]) begin g[k] = i; k++; end
    for (int i = 0; i < k; i++) begin
      e_sel[d][m+1+i] = g[i];
      e_sv[d][m+1+i]  = 1;
      e_ov[d][m+2+i]  = 1;
      e_idx[d][m+2+i] = g[i];
    end
    if (k > 0) e_last[d][m+k+1] = 1;
    e_done[d][m+k+1] = 1;
    for (int j = m + k + 1; j < SZ; j++) e_cnt[d][j] = k;
    for (int j = m; j <= m + k; j++) e_busy[d][j] = 1;
    next_acc[d] = m + k + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1'b1;
      for (int d = 0; d < 2; d++) begin
        wipe(d, cyc);
        next_acc[d] = cyc + 1;
      end
    end else if (start) begin
      for (int d = 0; d < 2; d++)
        if (cyc >= next_acc[d]) frame(d, cyc, req);
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed && cyc < SZ) begin
      for (int d = 0; d < 2; d++) begin
        s_log[d][cyc] = int'(sel[d]);   x_log[d][cyc] = int'(o_idx[d]);
        l_log[d][cyc] = int'(o_last[d]); v_log[d][cyc] = int'(o_valid[d]);
        d_log[d][cyc] = int'(done[d]);  c_log[d][cyc] = int'(o_cnt[d]);
        check($sformatf("d%0d_sel", d),     int'(sel[d]),     e_sel[d][cyc]);
        check($sformatf("d%0d_sel_vld", d), int'(sel_vld[d]), e_sv[d][cyc]);
        check($sformatf("d%0d_o_valid", d), int'(o_valid[d]), e_ov[d][cyc]);
        check($sformatf("d%0d_o_idx", d),   int'(o_idx[d]),   e_idx[d][cyc]);
        check($sformatf("d%0d_o_last", d),  int'(o_last[d]),  e_last[d][cyc]);
        check($sformatf("d%0d_done", d),    int'(done[d]),    e_done[d][cyc]);
        check($sformatf("d%0d_o_cnt", d),   int'(o_cnt[d]),   e_cnt[d][cyc]);
        check($sformatf("d%0d_busy", d),    int'(busy[d]),    e_busy[d][cyc]);
      end
    end
  end

  int m, m2;

  initial begin
    rst = 1'b1; start = 1'b0; req = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel", int'(sel[0]), 8);
    check("rst_busy", int'(busy[0]), 0);

    // Mask test: A6 -> 1,2,5,7
    m = cyc + 1; start = 1'b1; req = 8'hA6;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (8) @(negedge clk);
    check("mask_sel_a", s_log[0][m+1], 1);
    check("mask_sel_b", s_log[0][m+2], 2);
    check("mask_sel_c", s_log[0][m+3], 5);
    check("mask_sel_d", s_log[0][m+4], 7);
    check("mask_sel_idle", s_log[0][m+5], 8);
    check("mask_first_idx", x_log[0][m+2], 1);
    check("mask_first_valid", v_log[0][m+2], 1);
    check("mask_last", l_log[0][m+5], 1);
    check("mask_last_idx", x_log[0][m+5], 7);
    check("mask_done", d_log[0][m+5], 1);
    check("mask_cnt", c_log[0][m+5], 4);
    check("mask_cnt_max3", c_log[1][m+4], 3);

    // Truncation: FF with MAX_GRANTS=3 -> 0,1,2 then idle
    m = cyc + 1; start = 1'b1; req = 8'hFF;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (12) @(negedge clk);
    check("trunc_sel_a", s_log[1][m+1], 0);
    check("trunc_sel_b", s_log[1][m+2], 1);
    check("trunc_sel_c", s_log[1][m+3], 2);
    check("trunc_sel_idle", s_log[1][m+4], 8);
    check("trunc_cnt", c_log[1][m+4], 3);
    check("full_cnt", c_log[0][m+9], 8);

    // Empty frame
    m = cyc + 1; start = 1'b1; req = 8'h00;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("empty_done", d_log[0][m+1], 1);
    check("empty_cnt", c_log[0][m+1], 0);
    for (int j = m; j <= m + 3; j++) begin
      check("empty_no_valid", v_log[0][j], 0);
      check("empty_sel_idle", s_log[0][j], 8);
    end

    // Start held during SCAN is ignored
    m = cyc + 1; start = 1'b1; req = 8'h0F;
    @(negedge clk); req = 8'hF0;
    repeat (3) @(negedge clk);
    start = 1'b0; req = 8'h00;
    repeat (8) @(negedge clk);
    check("held_sel_last", s_log[0][m+4], 3);
    check("held_sel_idle", s_log[0][m+6], 8);
    check("held_cnt", c_log[0][m+5], 4);

    // Back-to-back: start in DONE, single idle gap
    m = cyc + 1; start = 1'b1; req = 8'h03;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1; req = 8'h01;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (6) @(negedge clk);
    check("b2b_sel_a", s_log[0][m+1], 0);
    check("b2b_sel_b", s_log[0][m+2], 1);
    check("b2b_gap", s_log[0][m+3], 8);
    check("b2b_sel_next", s_log[0][m+4], 0);
    check("b2b_done_a", d_log[0][m+3], 1);
    check("b2b_done_b", d_log[0][m+5], 1);
    check("b2b_cnt", c_log[0][m+5], 1);

    // Reset after three grants
    m = cyc + 1; start = 1'b1; req = 8'hFF;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (3) @(negedge clk);
    check("mid_third_grant", s_log[0][m+3], 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sel", int'(sel[0]), 8);
    check("mid_rst_sel_vld", int'(sel_vld[0]), 0);
    check("mid_rst_o_valid", int'(o_valid[0]), 0);
    check("mid_rst_o_idx", int'(o_idx[0]), 0);
    check("mid_rst_o_last", int'(o_last[0]), 0);
    check("mid_rst_done", int'(done[0]), 0);
    check("mid_rst_o_cnt", int'(o_cnt[0]), 0);
    check("mid_rst_busy", int'(busy[0]), 0);
    rst = 1'b0;
    m2 = cyc + 1; start = 1'b1; req = 8'h80;
    @(negedge clk); start = 1'b0; req = 8'h00;
    repeat (5) @(negedge clk);
    check("post_rst_sel", s_log[0][m2+1], 7);
    check("post_rst_done", d_log[0][m2+2], 1);
    check("post_rst_cnt", c_log[0][m2+2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
